// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared opcodes, DDRAM map, FSM states and address helpers
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam logic [7:0] CMD_SET_DDRAM  = 8'h80;
    localparam logic [7:0] CMD_SET_CGRAM  = 8'h40;
    localparam logic [7:0] CMD_FUNC_SET   = 8'h20;
    localparam logic [7:0] CMD_SHIFT      = 8'h10;
    localparam logic [7:0] CMD_DISP_CTRL  = 8'h08;
    localparam logic [7:0] CMD_ENTRY_MODE = 8'h04;
    localparam logic [7:0] CMD_HOME       = 8'h02;
    localparam logic [7:0] CMD_CLEAR      = 8'h01;

    localparam logic [6:0] DDRAM_LINE0_BASE = 7'h00;
    localparam logic [6:0] DDRAM_LINE0_END  = 7'h27;
    localparam logic [6:0] DDRAM_LINE1_BASE = 7'h40;
    localparam logic [6:0] DDRAM_LINE1_END  = 7'h67;
    localparam int         DDRAM_LINE_LEN   = 40;
    localparam int         DDRAM_DEPTH      = 80;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_FILL = 2'd2,
        ST_BUSY = 2'd3
    } state_t;

    function automatic logic addr_valid(input logic [6:0] a);
        return (a <= DDRAM_LINE0_END) ||
               ((a >= DDRAM_LINE1_BASE) && (a <= DDRAM_LINE1_END));
    endfunction

    // Line 1 is stored directly after line 0 in the linear array
    function automatic logic [6:0] ddram_index(input logic [6:0] a);
        return a[6] ? (7'(DDRAM_LINE_LEN) + {1'b0, a[5:0]}) : a;
    endfunction

    function automatic logic [6:0] ac_next(input logic [6:0] ac, input logic id);
        logic [6:0] n;
        if (id) begin
            if (ac == DDRAM_LINE0_END)      n = DDRAM_LINE1_BASE;
            else if (ac == DDRAM_LINE1_END) n = DDRAM_LINE0_BASE;
            else                            n = ac + 7'd1;
        end else begin
            if (ac == DDRAM_LINE0_BASE)      n = DDRAM_LINE1_END;
            else if (ac == DDRAM_LINE1_BASE) n = DDRAM_LINE0_END;
            else                             n = ac - 7'd1;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_ddram.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ddram
// Description : 80x8 display RAM, one write port, two registered read ports
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] host_addr,
    output logic [7:0] host_q,
    input  logic [6:0] disp_addr,
    output logic [7:0] disp_q
);

    logic [7:0] mem [DDRAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we && addr_valid(waddr)) begin
            mem[ddram_index(waddr)] <= wdata;
        end
    end

    // Reads sample the pre-write contents, so a colliding read sees old data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_q <= 8'h00;
            disp_q <= 8'h00;
        end else begin
            host_q <= addr_valid(host_addr) ? mem[ddram_index(host_addr)] : 8'h00;
            disp_q <= addr_valid(disp_addr) ? mem[ddram_index(disp_addr)] : 8'h00;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_char_responder.sv
`default_nettype none
// ============================================================================
// Module      : lcd_char_responder
// Description : HD44780-style 8-bit LCD bus target backed by an 80-byte DDRAM
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_char_responder
    import lcd_pkg::*;
#(
    parameter int         SYNC_STAGES      = 2,
    parameter int         BUSY_CYCLES      = 1850,
    parameter int         BUSY_LONG_CYCLES = 76000,
    parameter int         BUSY_W           = 17,
    parameter logic [7:0] BLANK_CHAR       = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    inout  wire  [7:0] LCD_data,
    input  logic [6:0] disp_addr,
    output logic [7:0] disp_char,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic [6:0] cursor_addr,
    output logic       err_busy
);

    localparam logic [BUSY_W-1:0] LOAD_SHORT = BUSY_W'(BUSY_CYCLES - 1);
    localparam logic [BUSY_W-1:0] LOAD_LONG  = BUSY_W'(BUSY_LONG_CYCLES - 1);

    logic [SYNC_STAGES-1:0]      e_sync, rs_sync, rw_sync;
    logic [SYNC_STAGES-1:0][7:0] data_sync;
    logic                        e_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_sync    <= '0;
            rs_sync   <= '0;
            rw_sync   <= '0;
            data_sync <= '0;
            e_d       <= 1'b0;
        end else begin
            e_sync    <= {e_sync[SYNC_STAGES-2:0], LCD_E};
            rs_sync   <= {rs_sync[SYNC_STAGES-2:0], LCD_RS};
            rw_sync   <= {rw_sync[SYNC_STAGES-2:0], LCD_RW};
            data_sync <= {data_sync[SYNC_STAGES-2:0], LCD_data};
            e_d       <= e_sync[SYNC_STAGES-1];
        end
    end

    logic       e_s, rs_s, rw_s, fall;
    logic [7:0] data_s;
    assign e_s    = e_sync[SYNC_STAGES-1];
    assign rs_s   = rs_sync[SYNC_STAGES-1];
    assign rw_s   = rw_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = e_d & ~e_s;

    state_t            state, state_n;
    logic [6:0]        ac, ac_n, fill_addr, fill_n;
    logic              id, id_n, is_data, is_data_n, err_n, bf;
    logic [2:0]        dcb, dcb_n;
    logic [BUSY_W-1:0] cnt, cnt_n;
    logic [7:0]        cmd, cmd_n;
    logic              we;
    logic [6:0]        waddr;
    logic [7:0]        wdata, host_q, rd_val;

    assign bf = (state != ST_IDLE);

    // Reset lands in FILL so the panel is blanked before firmware sees BF=0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_FILL;
            ac        <= 7'h00;
            id        <= 1'b1;
            dcb       <= 3'b000;
            cnt       <= LOAD_LONG;
            fill_addr <= DDRAM_LINE0_BASE;
            cmd       <= 8'h00;
            is_data   <= 1'b0;
            err_busy  <= 1'b0;
        end else begin
            state     <= state_n;
            ac        <= ac_n;
            id        <= id_n;
            dcb       <= dcb_n;
            cnt       <= cnt_n;
            fill_addr <= fill_n;
            cmd       <= cmd_n;
            is_data   <= is_data_n;
            err_busy  <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        ac_n      = ac;
        id_n      = id;
        dcb_n     = dcb;
        cnt_n     = cnt;
        fill_n    = fill_addr;
        cmd_n     = cmd;
        is_data_n = is_data;
        we        = 1'b0;
        waddr     = ac;
        wdata     = cmd;
        err_n     = fall & bf & ~(rw_s & ~rs_s);

        case (state)
            ST_IDLE: begin
                if (fall) begin
                    if (rw_s) begin
                        if (rs_s) ac_n = ac_next(ac, id);
                    end else if (rs_s || (data_s != 8'h00)) begin
                        cmd_n     = data_s;
                        is_data_n = rs_s;
                        state_n   = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_n = ST_BUSY;
                cnt_n   = LOAD_SHORT;
                if (is_data) begin
                    we   = 1'b1;
                    ac_n = ac_next(ac, id);
                end else if ((cmd & CMD_SET_DDRAM) != 8'h00) begin
                    ac_n = addr_valid(cmd[6:0]) ? cmd[6:0] : 7'h00;
                end else if ((cmd & (CMD_SET_CGRAM | CMD_FUNC_SET | CMD_SHIFT)) != 8'h00) begin
                    ac_n = ac;
                end else if ((cmd & CMD_DISP_CTRL) != 8'h00) begin
                    dcb_n = cmd[2:0];
                end else if ((cmd & CMD_ENTRY_MODE) != 8'h00) begin
                    id_n = cmd[1];
                end else if ((cmd & CMD_HOME) != 8'h00) begin
                    ac_n  = 7'h00;
                    cnt_n = LOAD_LONG;
                end else begin
                    ac_n    = 7'h00;
                    id_n    = 1'b1;
                    cnt_n   = LOAD_LONG;
                    fill_n  = DDRAM_LINE0_BASE;
                    state_n = ST_FILL;
                end
            end
            ST_FILL: begin
                we     = 1'b1;
                waddr  = fill_addr;
                wdata  = BLANK_CHAR;
                fill_n = ac_next(fill_addr, 1'b1);
                if (cnt != '0) cnt_n = cnt - 1'b1;
                if (fill_addr == DDRAM_LINE1_END) state_n = ST_BUSY;
            end
            ST_BUSY: begin
                if (cnt != '0) cnt_n = cnt - 1'b1;
                if (cnt <= BUSY_W'(1)) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    lcd_ddram u_ddram (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .host_addr (ac),
        .host_q    (host_q),
        .disp_addr (disp_addr),
        .disp_q    (disp_char)
    );

    assign rd_val      = rs_s ? host_q : {bf, ac};
    assign LCD_data    = (e_s & rw_s) ? rd_val : 8'bz;
    assign disp_on     = dcb[2];
    assign cursor_on   = dcb[1];
    assign blink_on    = dcb[0];
    assign cursor_addr = ac;

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_char_responder
// Description : Self-checking bench with a linear-position DDRAM/AC model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_char_responder;

    localparam int BUSY = 40;
    localparam int LONG = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic       host_oe = 1'b0;
    logic [7:0] host_dout = 8'h00;
    wire  [7:0] lcd_data;
    logic [6:0] disp_addr = 7'h00;
    logic [7:0] disp_char;
    logic       disp_on, cursor_on, blink_on, err_busy;
    logic [6:0] cursor_addr;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    logic [7:0] m_mem [0:127];
    logic [6:0] m_ac;
    logic       m_id;

    assign lcd_data = host_oe ? host_dout : 8'bz;
    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup (lcd_data[i]);
    end

    always #5 clk = ~clk;
    always @(negedge clk) if (err_busy === 1'b1) err_pulses <= err_pulses + 1;

    lcd_char_responder #(
        .SYNC_STAGES(2), .BUSY_CYCLES(BUSY), .BUSY_LONG_CYCLES(LONG),
        .BUSY_W(17), .BLANK_CHAR(8'h20)
    ) dut (
        .clk(clk), .reset(reset), .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw),
        .LCD_data(lcd_data), .disp_addr(disp_addr), .disp_char(disp_char),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .cursor_addr(cursor_addr), .err_busy(err_busy)
    );

    // Reference address arithmetic: the 80 cells form one ring of positions
    function automatic int lin(input logic [6:0] a);
        return (a >= 7'h40) ? 40 + int'(a) - 64 : int'(a);
    endfunction
    function automatic logic [6:0] hd(input int p);
        return (p >= 40) ? 7'(64 + p - 40) : 7'(p);
    endfunction
    function automatic logic [6:0] step_ac(input logic [6:0] a, input logic inc);
        return hd((lin(a) + (inc ? 1 : 79)) % 80);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d);
        lcd_rs = rs; lcd_rw = 1'b0; host_dout = d; host_oe = 1'b1;
        step(1); lcd_e = 1'b1; step(6); lcd_e = 1'b0; step(4);
        host_oe = 1'b0;
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] v);
        lcd_rs = rs; lcd_rw = 1'b1; host_oe = 1'b0;
        step(1); lcd_e = 1'b1; step(6); v = lcd_data; lcd_e = 1'b0; step(4);
        lcd_rw = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output int elapsed, output logic [7:0] st);
        elapsed = 0; st = 8'h80;
        while (st[7] && elapsed <= budget) begin
            bus_read(1'b0, st);
            elapsed += 11;
        end
    endtask

    task automatic disp_read(input logic [6:0] a, output logic [7:0] v);
        disp_addr = a; step(1); v = disp_char;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
        m_ac = 7'h00; m_id = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] v; int el; int bad;
        #1 reset = 1'b1;
        step(3);
        checks++; if (disp_char !== 8'h00) begin errors++; $display("FAIL reset_disp_char: got %h want 00", disp_char); end
        checks++; if ({disp_on, cursor_on, blink_on, err_busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {disp_on, cursor_on, blink_on, err_busy}); end
        checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL reset_ac: got %h want 00", cursor_addr); end
        checks++; if (lcd_data !== 8'hFF) begin errors++; $display("FAIL reset_bus_released: got %h want FF", lcd_data); end
        reset = 1'b0;
        model_clear();
        bus_read(1'b0, v);
        checks++; if (v !== 8'h80) begin errors++; $display("FAIL reset_first_bf: got %h want 80", v); end
        wait_ready(LONG + 100, el, v);
        el += 11;
        checks++; if (el < LONG || el > LONG + 16) begin errors++; $display("FAIL reset_busy_len: got %0d want %0d..%0d", el, LONG, LONG + 16); end
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", v); end
        bad = 0;
        for (int p = 0; p < 80; p++) begin
            disp_read(hd(p), v);
            if (v !== 8'h20) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_blank: got %0d bad cells want 0", bad); end
    endtask

    task automatic test_write_data();
        logic [7:0] v; int el;
        bus_write(1'b0, 8'h06); m_id = 1'b1;
        wait_ready(BUSY + 50, el, v);
        bus_write(1'b1, 8'h41);
        wait_ready(BUSY + 50, el, v);
        checks++; if (el < BUSY || el > BUSY + 16) begin errors++; $display("FAIL data_busy_len_1: got %0d want %0d..%0d", el, BUSY, BUSY + 16); end
        bus_write(1'b1, 8'h42);
        wait_ready(BUSY + 50, el, v);
        checks++; if (el < BUSY || el > BUSY + 16) begin errors++; $display("FAIL data_busy_len_2: got %0d want %0d..%0d", el, BUSY, BUSY + 16); end
        m_mem[0] = 8'h41; m_mem[1] = 8'h42; m_ac = 7'h02;
        disp_read(7'h00, v);
        checks++; if (v !== m_mem[0]) begin errors++; $display("FAIL data_cell0: got %h want %h", v, m_mem[0]); end
        disp_read(7'h01, v);
        checks++; if (v !== m_mem[1]) begin errors++; $display("FAIL data_cell1: got %h want %h", v, m_mem[1]); end
        bus_read(1'b0, v);
        checks++; if (v !== {1'b0, m_ac}) begin errors++; $display("FAIL data_status: got %h want %h", v, {1'b0, m_ac}); end
    endtask

    task automatic test_wrap();
        logic [7:0] v; int el;
        bus_write(1'b0, 8'hA7); wait_ready(BUSY + 50, el, v); m_ac = 7'h27;
        bus_write(1'b1, 8'h5A); wait_ready(BUSY + 50, el, v);
        m_mem[m_ac] = 8'h5A; m_ac = step_ac(m_ac, m_id);
        bus_read(1'b0, v);
        checks++; if (v !== {1'b0, m_ac}) begin errors++; $display("FAIL wrap_inc_ac: got %h want %h", v, {1'b0, m_ac}); end
        disp_read(7'h27, v);
        checks++; if (v !== m_mem[8'h27]) begin errors++; $display("FAIL wrap_cell27: got %h want %h", v, m_mem[8'h27]); end
        bus_write(1'b0, 8'h04); wait_ready(BUSY + 50, el, v); m_id = 1'b0;
        bus_write(1'b0, 8'h80); wait_ready(BUSY + 50, el, v); m_ac = 7'h00;
        bus_write(1'b1, 8'h66); wait_ready(BUSY + 50, el, v);
        m_mem[m_ac] = 8'h66; m_ac = step_ac(m_ac, m_id);
        bus_read(1'b0, v);
        checks++; if (v !== {1'b0, m_ac}) begin errors++; $display("FAIL wrap_dec_ac: got %h want %h", v, {1'b0, m_ac}); end
        bus_write(1'b0, 8'hB0); wait_ready(BUSY + 50, el, v); m_ac = 7'h00;
        bus_write(1'b0, 8'h06); wait_ready(BUSY + 50, el, v); m_id = 1'b1;
        bus_read(1'b0, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL wrap_clamp: got %h want 00", v); end
    endtask

    task automatic test_display_ctrl();
        logic [7:0] v; int el; int bad;
        bus_write(1'b0, 8'h0F); wait_ready(BUSY + 50, el, v);
        checks++; if ({disp_on, cursor_on, blink_on} !== 3'b111) begin errors++; $display("FAIL dcb_all: got %b want 111", {disp_on, cursor_on, blink_on}); end
        bus_write(1'b0, 8'h0A); wait_ready(BUSY + 50, el, v);
        checks++; if ({disp_on, cursor_on, blink_on} !== 3'b010) begin errors++; $display("FAIL dcb_mix: got %b want 010", {disp_on, cursor_on, blink_on}); end
        bus_write(1'b0, 8'h04); wait_ready(BUSY + 50, el, v); m_id = 1'b0;
        bus_write(1'b0, 8'h01);
        model_clear();
        wait_ready(LONG + 100, el, v);
        checks++; if (el < LONG || el > LONG + 16) begin errors++; $display("FAIL clear_busy_len: got %0d want %0d..%0d", el, LONG, LONG + 16); end
        bad = 0;
        for (int p = 0; p < 80; p++) begin
            disp_read(hd(p), v);
            if (v !== 8'h20) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_blank: got %0d bad cells want 0", bad); end
        bus_write(1'b1, 8'h99); wait_ready(BUSY + 50, el, v);
        m_mem[m_ac] = 8'h99; m_ac = step_ac(m_ac, m_id);
        bus_read(1'b0, v);
        checks++; if (v !== {1'b0, m_ac}) begin errors++; $display("FAIL clear_id_reset: got %h want %h", v, {1'b0, m_ac}); end
    endtask

    task automatic test_err_busy();
        logic [7:0] v; int el; int e0; logic [6:0] a0;
        a0 = m_ac;
        e0 = err_pulses;
        bus_write(1'b1, 8'h33);
        m_mem[m_ac] = 8'h33; m_ac = step_ac(m_ac, m_id);
        bus_write(1'b1, 8'h77);
        checks++; if (err_pulses - e0 != 1) begin errors++; $display("FAIL err_pulse: got %0d pulse clks want 1", err_pulses - e0); end
        e0 = err_pulses;
        bus_read(1'b0, v);
        checks++; if (v !== {1'b1, m_ac}) begin errors++; $display("FAIL err_bf_status: got %h want %h", v, {1'b1, m_ac}); end
        checks++; if (err_pulses != e0) begin errors++; $display("FAIL err_bf_read_pulse: got %0d want 0", err_pulses - e0); end
        wait_ready(BUSY + 50, el, v);
        checks++; if (v !== {1'b0, m_ac}) begin errors++; $display("FAIL err_ac: got %h want %h", v, {1'b0, m_ac}); end
        disp_read(a0, v);
        checks++; if (v !== m_mem[a0]) begin errors++; $display("FAIL err_cell_a: got %h want %h", v, m_mem[a0]); end
        disp_read(m_ac, v);
        checks++; if (v !== m_mem[m_ac]) begin errors++; $display("FAIL err_cell_b: got %h want %h", v, m_mem[m_ac]); end
    endtask

    task automatic test_random();
        logic [7:0] v, d; int el; int op; logic [6:0] a;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    a = hd($urandom_range(0, 79));
                    bus_write(1'b0, {1'b1, a}); m_ac = a;
                    wait_ready(BUSY + 50, el, v);
                end
                1: begin
                    d = 8'($urandom_range(0, 255));
                    bus_write(1'b1, d);
                    m_mem[m_ac] = d; m_ac = step_ac(m_ac, m_id);
                    wait_ready(BUSY + 50, el, v);
                end
                2: begin
                    bus_read(1'b1, v);
                    checks++; if (v !== m_mem[m_ac]) begin errors++; $display("FAIL rnd_data_read it%0d: got %h want %h", it, v, m_mem[m_ac]); end
                    m_ac = step_ac(m_ac, m_id);
                end
                3: begin
                    m_id = 1'($urandom_range(0, 1));
                    bus_write(1'b0, {6'b000001, m_id, 1'b0});
                    wait_ready(BUSY + 50, el, v);
                end
                default: begin
                    a = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(8'h28, 8'h3F))
                                                     : 7'($urandom_range(8'h68, 8'h7F));
                    bus_write(1'b0, {1'b1, a}); m_ac = 7'h00;
                    wait_ready(BUSY + 50, el, v);
                end
            endcase
            bus_read(1'b0, v);
            checks++; if (v !== {1'b0, m_ac}) begin errors++; $display("FAIL rnd_status it%0d op%0d: got %h want %h", it, op, v, {1'b0, m_ac}); end
        end
        for (int k = 0; k < 12; k++) begin
            a = hd($urandom_range(0, 79));
            disp_read(a, v);
            checks++; if (v !== m_mem[a]) begin errors++; $display("FAIL rnd_disp %h: got %h want %h", a, v, m_mem[a]); end
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [7:0] v; int el; int bad;
        bus_write(1'b0, 8'h0F); wait_ready(BUSY + 50, el, v);
        bus_write(1'b0, 8'hE0); wait_ready(BUSY + 50, el, v);
        bus_write(1'b1, 8'h55); wait_ready(BUSY + 50, el, v);
        bus_write(1'b0, 8'h01);
        step(20);
        lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_e = 1'b1;
        step(4);
        checks++; if (lcd_data !== 8'h80) begin errors++; $display("FAIL midfill_drive: got %h want 80", lcd_data); end
        #2 reset = 1'b1;
        #1;
        checks++; if (lcd_data !== 8'hFF) begin errors++; $display("FAIL midfill_release: got %h want FF", lcd_data); end
        checks++; if ({disp_on, cursor_on, blink_on, disp_char} !== 11'h000) begin errors++; $display("FAIL midfill_reset_outs: got %h want 000", {disp_on, cursor_on, blink_on, disp_char}); end
        step(3);
        lcd_e = 1'b0; lcd_rw = 1'b0;
        reset = 1'b0;
        step(59);
        disp_read(7'h60, v);
        checks++; if (v !== 8'h55) begin errors++; $display("FAIL midfill_restart: got %h want 55", v); end
        model_clear();
        wait_ready(LONG + 100, el, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL midfill_status: got %h want 00", v); end
        bad = 0;
        for (int p = 0; p < 80; p++) begin
            disp_read(hd(p), v);
            if (v !== 8'h20) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL midfill_blank: got %0d bad cells want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_write_data();
        test_wrap();
        test_display_ctrl();
        test_err_busy();
        test_random();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
